// File: rtl/pwm_pkg.sv
// Shared types for the PWM generator family: output alignment mode and
// timebase count direction.
package pwm_pkg;

  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t;
  typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_t;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: up-counter (edge) or up/down counter (center) with a
// period-boundary strobe and the mode latched at that boundary.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output pwm_dir_t         dir,
  output pwm_mode_t        mode_act,
  output logic             run,
  output logic             boundary
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             en_d;
  logic [WIDTH-1:0] count_nxt;
  pwm_dir_t         dir_nxt;
  pwm_mode_t        mode_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      dir      <= DIR_UP;
      mode_act <= PWM_EDGE;
      en_d     <= 1'b0;
    end else begin
      count    <= count_nxt;
      dir      <= dir_nxt;
      mode_act <= mode_nxt;
      en_d     <= en;
    end
  end

  // The first enabled edge after a parked cycle restarts the period, so the
  // compare stage only runs once the timebase has actually left the park state.
  always_comb begin
    count_nxt = count;
    dir_nxt   = dir;
    mode_nxt  = mode_act;
    boundary  = 1'b0;
    run       = en && en_d;
    if (!en) begin
      count_nxt = '0;
      dir_nxt   = DIR_UP;
    end else if (!en_d) begin
      boundary  = 1'b1;
      count_nxt = '0;
      dir_nxt   = DIR_UP;
    end else if (mode_act == PWM_EDGE) begin
      count_nxt = count + ONE;
      dir_nxt   = DIR_UP;
      boundary  = (count == MAX);
    end else if (dir == DIR_UP) begin
      if (count == MAX) dir_nxt = DIR_DOWN;
      else              count_nxt = count + ONE;
    end else begin
      if (count == '0) begin
        dir_nxt  = DIR_UP;
        boundary = 1'b1;
      end else begin
        count_nxt = count - ONE;
      end
    end
    if (boundary) mode_nxt = pwm_mode_t'(mode);
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared timebase, double-buffered duty per
// channel loaded at the period boundary, registered outputs for the pads.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [CHANNELS*WIDTH-1:0] sample,
  input  logic                      sample_valid,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start
);

  logic [WIDTH-1:0] count;
  pwm_dir_t         dir;
  pwm_mode_t        mode_act;
  logic             run;
  logic             boundary;

  // Center-aligned pulses are placed around the count=MAX turnaround by
  // comparing against the mirrored count (MAX - count).
  function automatic logic duty_hit(input logic [WIDTH-1:0] cnt,
                                    input logic [WIDTH-1:0] duty,
                                    input pwm_mode_t        m);
    logic [WIDTH-1:0] pos;
    pos = (m == PWM_CENTER) ? ~cnt : cnt;
    return pos < duty;
  endfunction

  pwm_timebase #(.WIDTH(WIDTH)) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .count    (count),
    .dir      (dir),
    .mode_act (mode_act),
    .run      (run),
    .boundary (boundary)
  );

  // Stage p1: compare result registered onto the pins.
  always_ff @(posedge clk) begin
    if (rst) period_start <= 1'b0;
    else     period_start <= run && (count == '0) && (dir == DIR_UP);
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] duty;
    logic             pwm_p1;

    always_ff @(posedge clk) begin
      if (rst) begin
        shadow <= '0;
        duty   <= '0;
        pwm_p1 <= 1'b0;
      end else begin
        if (sample_valid) shadow <= sample[k*WIDTH +: WIDTH];
        if (boundary)     duty   <= sample_valid ? sample[k*WIDTH +: WIDTH] : shadow;
        pwm_p1 <= run && duty_hit(count, duty, mode_act);
      end
    end

    assign pwm_out[k] = pwm_p1;
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a period-phase reference model predicts the
// pins every cycle, a monitor compares them against the DUT on the falling edge.
module tb_pwm_multi;

  localparam int W    = 4;
  localparam int CH   = 2;
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          mode;
  logic [CH*W-1:0] sample;
  logic          sample_valid;
  logic [CH-1:0] pwm_out;
  logic          period_start;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .sample       (sample),
    .sample_valid (sample_valid),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  // Reference model state: position within the current period, not a counter image.
  int m_run;
  int m_phase;
  int m_mode;
  int m_duty[CH];
  int m_shadow[CH];

  logic [CH:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  function automatic int period_len(input int md);
    return md ? 2 * (MAXV + 1) : MAXV + 1;
  endfunction

  function automatic bit expect_high(input int ph, input int d, input int md);
    int c;
    if (md == 0) return ph < d;
    c = (ph <= MAXV) ? ph : 2 * MAXV + 1 - ph;
    return (c + d) > MAXV;
  endfunction

  function automatic logic [CH*W-1:0] pack2(input int a, input int b);
    logic [W-1:0] xa;
    logic [W-1:0] xb;
    xa = a[W-1:0];
    xb = b[W-1:0];
    return {xb, xa};
  endfunction

  initial begin : model
    logic [CH:0] e;
    bit bnd;
    m_run = 0; m_phase = 0; m_mode = 0;
    for (int k = 0; k < CH; k++) begin m_duty[k] = 0; m_shadow[k] = 0; end
    forever begin
      @(posedge clk);
      e = '0;
      if (rst) begin
        m_run = 0; m_phase = 0; m_mode = 0;
        for (int k = 0; k < CH; k++) begin m_duty[k] = 0; m_shadow[k] = 0; end
      end else begin
        if (en && m_run != 0) begin
          e[CH] = (m_phase == 0);
          for (int k = 0; k < CH; k++) e[k] = expect_high(m_phase, m_duty[k], m_mode);
        end
        bnd = en && (m_run == 0 || m_phase == period_len(m_mode) - 1);
        if (bnd) begin
          for (int k = 0; k < CH; k++)
            m_duty[k] = sample_valid ? int'(sample[k*W +: W]) : m_shadow[k];
          m_mode  = int'(mode);
          m_phase = 0;
        end else if (en) begin
          m_phase = m_phase + 1;
        end else begin
          m_phase = 0;
        end
        if (sample_valid)
          for (int k = 0; k < CH; k++) m_shadow[k] = int'(sample[k*W +: W]);
        m_run = en ? 1 : 0;
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    logic [CH:0] e;
    forever begin
      @(negedge clk);
      cycle = cycle + 1;
      vectors = vectors + 1;
      if (exp_q.size() == 0) begin
        miscompares = miscompares + 1;
        $display("FAIL scoreboard cycle %0d: no expected entry, pins=%b", cycle, {period_start, pwm_out});
      end else begin
        e = exp_q.pop_front();
        if ({period_start, pwm_out} !== e) begin
          miscompares = miscompares + 1;
          $display("FAIL pins cycle %0d: {period_start,pwm_out} got %b expected %b (phase %0d mode %0d)",
                   cycle, {period_start, pwm_out}, e, m_phase, m_mode);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input logic [CH*W-1:0] s);
    sample       = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while (m_phase != p && n < 100) begin
      tick();
      n++;
    end
    vectors = vectors + 1;
    if (m_phase != p) begin
      miscompares = miscompares + 1;
      $display("FAIL wait_phase: phase %0d reached instead of %0d", m_phase, p);
    end
  endtask

  initial begin : stimulus
    logic [31:0] r;
    rst = 1'b1; en = 1'b0; mode = 1'b0; sample = '0; sample_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Edge mode, {ch1,ch0} = {0,3} loaded while parked.
    put(pack2(3, 0));
    en = 1'b1;
    repeat (40) tick();

    // Mid-period write of 12 at phase 6 with duty 4 active.
    put(pack2(4, 9));
    repeat (20) tick();
    wait_phase(6);
    put(pack2(12, 1));
    repeat (40) tick();

    // Write landing exactly on the boundary edge.
    wait_phase(MAXV);
    put(pack2(2, 15));
    repeat (20) tick();

    // Mode change mid-period, then center mode with duty 5.
    wait_phase(9);
    mode = 1'b1;
    repeat (40) tick();
    put(pack2(5, 15));
    repeat (70) tick();
    wait_phase(2 * MAXV + 1);
    put(pack2(7, 0));
    repeat (70) tick();
    mode = 1'b0;
    repeat (70) tick();

    // en dropped mid-period, shadow written while parked, then re-enabled.
    wait_phase(5);
    en = 1'b0;
    repeat (6) tick();
    put(pack2(6, 10));
    repeat (3) tick();
    en = 1'b1;
    repeat (40) tick();

    // Reset mid-period with duty 7 active.
    put(pack2(7, 7));
    repeat (20) tick();
    wait_phase(8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (40) tick();
    put(pack2(3, 11));
    repeat (40) tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      sample       = r[CH*W-1:0];
      sample_valid = ($urandom_range(0, 99) < 8);
      en           = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 99) < 3) mode = ~mode;
      rst          = ($urandom_range(0, 299) < 1);
      tick();
    end
    rst = 1'b0; en = 1'b1; sample_valid = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
